// File: rtl/slt_pkg.sv
// Shared definitions for the signed set-less-than comparator.
// This file provides the default operand width and the full-adder cell used by the ripple adder.
package slt_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef struct packed {
    logic carry;
    logic sum;
  } fa_t;

  // One-bit full adder cell; the ripple chain is a generate loop of these.
  function automatic fa_t full_adder(input logic a, input logic b, input logic cin);
    fa_t r;
    r.sum   = a ^ b ^ cin;
    r.carry = (a & b) | (a & cin) | (b & cin);
    return r;
  endfunction

endpackage

// File: rtl/adder_n.sv
// N-bit ripple-carry adder.
// The adder is a generate loop of full_adder cells with an explicit carry chain.
module adder_n
  import slt_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_cell
    fa_t w_cell;
    assign w_cell         = full_adder(a[i], b[i], w_carry[i]);
    assign sum[i]         = w_cell.sum;
    assign w_carry[i+1]   = w_cell.carry;
  end

  assign c_out = w_carry[N];

endmodule

// File: rtl/slt.sv
// Signed set-less-than: out = 1 iff a < b (two's complement).
// The module also provides out_q, a registered copy of out with an async active-high reset.
module slt
  import slt_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out,
  output logic         out_q
);

  logic [N-1:0] w_bInv;
  logic [N-1:0] w_diff;
  logic         w_unusedCarry;
  logic         w_ovf;
  logic         r_outQ;

  assign w_bInv = ~b;

  // diff = a - b as a + ~b + 1; the carry-out plays no part in the signed result
  adder_n #(.N(N)) u_sub (
    .a     (a),
    .b     (w_bInv),
    .c_in  (1'b1),
    .sum   (w_diff),
    .c_out (w_unusedCarry)
  );

  // Subtraction overflows only when the signs differ and the result sign flips away from a
  assign w_ovf = (a[N-1] != b[N-1]) & (w_diff[N-1] != a[N-1]);
  assign out   = w_diff[N-1] ^ w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_outQ <= 1'b0;
    else     r_outQ <= out;
  end

  assign out_q = r_outQ;

endmodule

// File: tb/tb_slt.sv
// Self-checking bench for slt: directed corner cases, random pairs against a signed-compare model,
// plus the reset behaviour of the registered output.
module tb_slt;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out;
  logic         out_q;

  int assertCount;
  int failCount;

  slt #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic refSlt(input logic [N-1:0] x, input logic [N-1:0] y);
    return $signed(x) < $signed(y);
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b (a=%h b=%h)", tag, observed, expected, a, b);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] newA, input logic [N-1:0] newB);
    @(negedge clk);
    a = newA;
    b = newB;
    #1;
  endtask

  logic [N-1:0] dirA [7];
  logic [N-1:0] dirB [7];
  logic         dirExp [7];

  initial begin
    logic         expOut;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    assertCount = 0;
    failCount   = 0;

    dirA = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF,
             32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    dirB = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
             32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    dirExp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    a   = '0;
    b   = '0;
    #2;
    checkOutput("reset_out_q", out_q, 1'b0);
    checkOutput("reset_out", out, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases, including both overflow directions and most-negative operands
    for (int i = 0; i < 7; i++) begin
      applyStimulus(dirA[i], dirB[i]);
      checkOutput("directed_out", out, dirExp[i]);
      @(posedge clk);
      #1;
      checkOutput("directed_out_q", out_q, dirExp[i]);
    end

    // Random pairs; every third one forces a sign mismatch to exercise overflow more often
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb[N-1] = ~ra[N-1];
      if (i % 17 == 0) rb = ra;
      applyStimulus(ra, rb);
      expOut = refSlt(ra, rb);
      checkOutput("random_out", out, expOut);
      @(posedge clk);
      #1;
      checkOutput("random_out_q", out_q, expOut);
    end

    // Mid-run async reset with out=1
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_out_q", out_q, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_out_q", out_q, 1'b0);
    checkOutput("out_during_reset", out, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("held_reset_out_q", out_q, 1'b0);

    applyStimulus(32'h0000_0005, 32'h8000_0000);
    checkOutput("out_tracks_in_reset", out, refSlt(a, b));
    applyStimulus(32'h8000_0000, 32'h0000_0005);
    checkOutput("out_tracks_in_reset2", out, 1'b1);

    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_deassert_out_q", out_q, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("first_edge_out_q", out_q, 1'b1);

    applyStimulus(32'h0000_0003, 32'h0000_0003);
    checkOutput("equal_out", out, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("equal_out_q", out_q, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
